dcache_wb_queue: RTL and testbench

Line-granular write-back queue between the DCache eviction path and the cache/AXI interface's DCache write channel. Dirty 256-bit victim lines are accepted in one cycle, merged by line address, and drained in FIFO order, one line per write-channel transaction. DCache refills therefore never wait behind a write-back. A combinational read-hazard port lets the DCache forward the newest queued copy of a line instead of refilling stale memory data.

---
 rtl/dcache_wb_queue.sv | 87 ++++++++
 tb/tb_dcache_wb_queue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb_queue.sv
// dcache_wb_queue: line-granular write-back FIFO with address merge, one-line drain FSM and read-hazard forwarding
module dcache_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wb_req_i,
  input  logic [31:0]  wb_addr_i,
  input  logic [255:0] wb_data_i,
  output logic         wb_full_o,
  output logic         wb_empty_o,
  output logic         data_wen_o,
  output logic [31:0]  data_awaddr_o,
  output logic [255:0] data_wdata_o,
  input  logic         data_bvalid_i,
  input  logic [31:0]  rd_addr_i,
  output logic         rd_hit_o,
  output logic [255:0] rd_hit_data_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
  state_t state;
  logic [DEPTH-1:0] valid;
  logic [26:0] tag [DEPTH];
  logic [255:0] data [DEPTH];
  logic [AW-1:0] head, tail, merge_idx, hit_idx, widx;
  logic [AW:0] count;
  logic merge_hit, hit, accept, alloc, retire;
  logic unused;
  assign unused = ^{wb_addr_i[4:0], rd_addr_i[4:0]};
  assign wb_full_o = count == (AW+1)'(DEPTH);
  assign wb_empty_o = count == '0 && state == IDLE;
  assign data_wen_o = state == SEND || (state == WAIT && !data_bvalid_i);
  assign data_awaddr_o = {tag[head], 5'b0};
  assign data_wdata_o = data[head];
  assign accept = wb_req_i && (merge_hit || !wb_full_o);
  assign alloc = accept && !merge_hit;
  assign retire = state == WAIT && data_bvalid_i;
  assign widx = merge_hit ? merge_idx : tail;
  // the head is excluded from merging once it has been handed to the interface
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (valid[i] && tag[i] == wb_addr_i[31:5] && !(state != IDLE && AW'(i) == head)) begin
        merge_hit = 1'b1;
        merge_idx = AW'(i);
      end
  end
  // a non-head match is younger than the head, so it overrides a head match
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (valid[i] && tag[i] == rd_addr_i[31:5] && (!hit || AW'(i) != head)) begin
        hit = 1'b1;
        hit_idx = AW'(i);
      end
  end
  assign rd_hit_o = hit;
  assign rd_hit_data_o = hit ? data[hit_idx] : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag[i] <= '0;
        data[i] <= '0;
      end
      head <= '0;
      tail <= '0;
      count <= '0;
      state <= IDLE;
    end else begin
      if (accept) begin
        valid[widx] <= 1'b1;
        tag[widx] <= wb_addr_i[31:5];
        data[widx] <= wb_data_i;
      end
      if (retire) valid[head] <= 1'b0;
      if (alloc) tail <= tail + 1'b1;
      if (retire) head <= head + 1'b1;
      count <= count + (AW+1)'(alloc) - (AW+1)'(retire);
      state <= state == IDLE ? (count != '0 ? SEND : IDLE) :
               state == SEND ? WAIT : (data_bvalid_i ? IDLE : WAIT);
    end
  end
endmodule

// File: tb/tb_dcache_wb_queue.sv
// tb_dcache_wb_queue: scenario tasks against a reference queue model with an in-order write scoreboard
module tb_dcache_wb_queue;
  localparam int DEPTH = 4;
  localparam int M_IDLE = 0, M_SEND = 1, M_WAIT = 2;
  typedef struct {
    logic [31:0]  addr;
    logic [255:0] data;
  } ent_t;
  logic clk = 1'b0, rst = 1'b1;
  logic wb_req_i = 1'b0, data_bvalid_i = 1'b0;
  logic [31:0] wb_addr_i = '0, rd_addr_i = '0;
  logic [255:0] wb_data_i = '0;
  logic wb_full_o, wb_empty_o, data_wen_o, rd_hit_o;
  logic [31:0] data_awaddr_o;
  logic [255:0] data_wdata_o, rd_hit_data_o;
  ent_t sb[$];
  int mstate = M_IDLE;
  int tests = 0, fails = 0;
  dcache_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wb_req_i(wb_req_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .wb_full_o(wb_full_o), .wb_empty_o(wb_empty_o), .data_wen_o(data_wen_o),
    .data_awaddr_o(data_awaddr_o), .data_wdata_o(data_wdata_o), .data_bvalid_i(data_bvalid_i),
    .rd_addr_i(rd_addr_i), .rd_hit_o(rd_hit_o), .rd_hit_data_o(rd_hit_data_o)
  );
  always #5 clk = ~clk;
  function automatic logic [255:0] mkdata(int s);
    logic [255:0] d;
    for (int w = 0; w < 8; w++) d[w*32 +: 32] = 32'h1000_0000 * s + 32'(w) * 32'h0001_0101 + 32'(s);
    return d;
  endfunction
  // advances one clock, updating the reference model from the inputs driven this cycle
  task automatic tick(output bit acc);
    int m = -1;
    int st = mstate != M_IDLE ? 1 : 0;
    int pre = sb.size();
    int nxt;
    bit retire;
    ent_t e;
    if (wb_req_i) for (int i = st; i < sb.size(); i++) if (sb[i].addr[31:5] == wb_addr_i[31:5]) m = i;
    acc = wb_req_i && (m >= 0 || pre != DEPTH);
    retire = mstate == M_WAIT && data_bvalid_i;
    nxt = mstate == M_IDLE ? (pre != 0 ? M_SEND : M_IDLE) : mstate == M_SEND ? M_WAIT : (data_bvalid_i ? M_IDLE : M_WAIT);
    if (acc && m >= 0) begin
      e = sb[m];
      e.data = wb_data_i;
      sb[m] = e;
    end else if (acc) begin
      e.addr = {wb_addr_i[31:5], 5'b0};
      e.data = wb_data_i;
      sb.push_back(e);
    end
    if (retire) void'(sb.pop_front());
    @(posedge clk);
    #1;
    mstate = nxt;
  endtask
  task automatic enq(input logic [31:0] a, input logic [255:0] d, output bit acc);
    wb_req_i = 1'b1;
    wb_addr_i = a;
    wb_data_i = d;
    tick(acc);
    wb_req_i = 1'b0;
  endtask
  task automatic drain_one(input string name);
    int n = 0;
    bit acc;
    while (mstate != M_WAIT && n < 10) begin
      tick(acc);
      n++;
    end
    tests++;
    if (mstate != M_WAIT || sb.size() == 0) begin
      fails++;
      $display("FAIL %s: no line pending in model (size %0d)", name, sb.size());
      return;
    end
    if (data_wen_o !== 1'b1 || data_awaddr_o !== sb[0].addr || data_wdata_o !== sb[0].data) begin
      fails++;
      $display("FAIL %s: wen %b addr %h data %h, want wen 1 addr %h data %h", name, data_wen_o, data_awaddr_o, data_wdata_o, sb[0].addr, sb[0].data);
    end
    data_bvalid_i = 1'b1;
    #1;
    tests++;
    if (data_wen_o !== 1'b0) begin
      fails++;
      $display("FAIL %s_bvalid_wen: got %b want 0", name, data_wen_o);
    end
    tick(acc);
    data_bvalid_i = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    #3;
    tests++;
    if ({data_wen_o, wb_full_o, wb_empty_o, rd_hit_o} !== 4'b0010 || data_awaddr_o !== '0 || data_wdata_o !== '0) begin
      fails++;
      $display("FAIL reset: wen/full/empty/hit %b%b%b%b addr %h, want 0010 addr 0", data_wen_o, wb_full_o, wb_empty_o, rd_hit_o, data_awaddr_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic test_single;
    bit acc;
    enq(32'h8000_0020, mkdata(1), acc);
    tests++;
    if (data_wen_o !== 1'b0 || wb_empty_o !== 1'b0) begin
      fails++;
      $display("FAIL single_bubble: wen %b empty %b, want 0 0", data_wen_o, wb_empty_o);
    end
    tick(acc);
    tests++;
    if (data_wen_o !== 1'b1 || data_awaddr_o !== 32'h8000_0020 || data_wdata_o !== mkdata(1)) begin
      fails++;
      $display("FAIL single_send: wen %b addr %h, want 1 80000020", data_wen_o, data_awaddr_o);
    end
    drain_one("single_drain");
    tests++;
    if (wb_empty_o !== 1'b1) begin
      fails++;
      $display("FAIL single_empty: got %b want 1", wb_empty_o);
    end
  endtask
  task automatic test_full;
    bit acc;
    for (int i = 0; i < DEPTH; i++) enq(32'h0001_0000 + 32'(i) * 32'h40, mkdata(10 + i), acc);
    tests++;
    if (wb_full_o !== (sb.size() == DEPTH)) begin
      fails++;
      $display("FAIL full_flag: got %b want %b", wb_full_o, sb.size() == DEPTH);
    end
    enq(32'h0002_0000, mkdata(20), acc);
    rd_addr_i = 32'h0002_0000;
    #1;
    tests++;
    if (rd_hit_o !== acc || wb_full_o !== 1'b1) begin
      fails++;
      $display("FAIL full_reject: hit %b full %b, want hit %b full 1", rd_hit_o, wb_full_o, acc);
    end
    for (int i = 0; i < DEPTH; i++) drain_one($sformatf("full_drain%0d", i));
    tests++;
    if (wb_empty_o !== 1'b1) begin
      fails++;
      $display("FAIL full_empty: got %b want 1", wb_empty_o);
    end
  endtask
  task automatic test_merge;
    bit acc;
    enq(32'h0000_0000, mkdata(30), acc);
    enq(32'h0000_0100, mkdata(31), acc);
    enq(32'h0000_0200, mkdata(32), acc);
    enq(32'h0000_0100, mkdata(33), acc);
    rd_addr_i = 32'h0000_0108;
    #1;
    tests++;
    if (rd_hit_o !== 1'b1 || rd_hit_data_o !== mkdata(33) || sb.size() != 3) begin
      fails++;
      $display("FAIL merge_hit: hit %b data %h, want 1 %h (model size %0d)", rd_hit_o, rd_hit_data_o, mkdata(33), sb.size());
    end
    for (int i = 0; i < 3; i++) drain_one($sformatf("merge_drain%0d", i));
    tests++;
    if (wb_empty_o !== 1'b1) begin
      fails++;
      $display("FAIL merge_empty: got %b want 1", wb_empty_o);
    end
  endtask
  task automatic test_inflight;
    bit acc;
    enq(32'h0000_0300, mkdata(40), acc);
    tick(acc);
    enq(32'h0000_0300, mkdata(41), acc);
    rd_addr_i = 32'h0000_0304;
    #1;
    tests++;
    if (rd_hit_o !== 1'b1 || rd_hit_data_o !== mkdata(41)) begin
      fails++;
      $display("FAIL inflight_hit: hit %b data %h, want 1 %h", rd_hit_o, rd_hit_data_o, mkdata(41));
    end
    rd_addr_i = 32'h0000_0500;
    #1;
    tests++;
    if (rd_hit_o !== 1'b0 || rd_hit_data_o !== '0) begin
      fails++;
      $display("FAIL inflight_miss: hit %b data %h, want 0 0", rd_hit_o, rd_hit_data_o);
    end
    drain_one("inflight_p3");
    drain_one("inflight_p4");
  endtask
  task automatic test_back_to_back;
    bit acc;
    for (int i = 0; i < DEPTH; i++) enq(32'h0003_0000 + 32'(i) * 32'h20, mkdata(50 + i), acc);
    wb_req_i = 1'b1;
    wb_addr_i = 32'h0004_0000;
    wb_data_i = mkdata(60);
    data_bvalid_i = 1'b1;
    #1;
    tests++;
    if (wb_full_o !== 1'b1 || mstate != M_WAIT || data_awaddr_o !== sb[0].addr) begin
      fails++;
      $display("FAIL b2b_pre: full %b addr %h, want 1 %h", wb_full_o, data_awaddr_o, sb[0].addr);
    end
    tick(acc);
    wb_req_i = 1'b0;
    data_bvalid_i = 1'b0;
    rd_addr_i = 32'h0004_0000;
    #1;
    tests++;
    if (wb_full_o !== 1'b0 || rd_hit_o !== acc) begin
      fails++;
      $display("FAIL b2b_post: full %b hit %b, want 0 %b", wb_full_o, rd_hit_o, acc);
    end
    for (int i = 0; i < DEPTH - 1; i++) drain_one($sformatf("b2b_drain%0d", i));
    tests++;
    if (wb_empty_o !== 1'b1) begin
      fails++;
      $display("FAIL b2b_empty: got %b want 1", wb_empty_o);
    end
  endtask
  task automatic test_reset_mid;
    bit acc;
    int n = 0;
    enq(32'h0000_0700, mkdata(70), acc);
    while (mstate != M_WAIT && n < 10) begin
      tick(acc);
      n++;
    end
    rd_addr_i = 32'h0000_0700;
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({data_wen_o, wb_full_o, wb_empty_o, rd_hit_o} !== 4'b0010 || data_awaddr_o !== '0 || data_wdata_o !== '0) begin
      fails++;
      $display("FAIL reset_mid: wen/full/empty/hit %b%b%b%b addr %h, want 0010 addr 0", data_wen_o, wb_full_o, wb_empty_o, rd_hit_o, data_awaddr_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    mstate = M_IDLE;
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      tests++;
      if (data_wen_o !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid_idle%0d: wen %b want 0", i, data_wen_o);
      end
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_full;
    test_merge;
    test_inflight;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
